pool_window_feeder: RTL and testbench

Transmit side of the pooling-layer input protocol. Scans a feature map held in a synchronous-read RAM in 2x2 window order and presents each window as a one-cycle `strt` pulse followed by four consecutive data elements on `dout`. It sits between a conv-layer output buffer and the max-pool layer, and honours downstream `hold` at window boundaries only.

---
 rtl/pool_pkg.sv | 21 ++
 rtl/pool_window_feeder.sv | 146 ++++++++++++++
 tb/tb_pool_window_feeder.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types for the pooling-layer window feeder.
// Holds the feeder state encoding and the window-count helper.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S0,
        S1,
        S2,
        S3,
        S4,
        WAIT,
        DONE
    } feeder_state_t;

    // Number of 2x2 windows in a w x h map.
    function automatic int win_count(input int w, input int h);
        return (w / 2) * (h / 2);
    endfunction

endpackage

// File: rtl/pool_window_feeder.sv
// Scans a feature map in 2x2 window order and streams each window as a
// strt pulse plus four elements; downstream hold acts only between windows.
module pool_window_feeder
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int MAP_W      = 16,
    parameter int MAP_H      = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         go,
    input  logic                         tx_done,
    input  logic                         hold,
    output logic        [ADDR_WIDTH-1:0] rd_addr,
    input  logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         strt,
    output logic signed [DATA_WIDTH-1:0] dout,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int NWIN   = win_count(MAP_W, MAP_H);
    localparam int HALF_W = MAP_W / 2;

    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] TWO      = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] W_A      = ADDR_WIDTH'(MAP_W);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(HALF_W - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NWIN / HALF_W - 1);

    feeder_state_t         state;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] row;
    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] nxt_base;
    logic [ADDR_WIDTH-1:0] nxt_row;
    logic [ADDR_WIDTH-1:0] nxt_col;
    logic                  last_win;

    assign dout     = rd_data;
    assign last_win = (col == LAST_COL) && (row == LAST_ROW);

    // Top-left address of the following window; wraps to the next window row.
    always_comb begin
        nxt_col  = col + ONE;
        nxt_row  = row;
        nxt_base = base + TWO;
        if (col == LAST_COL) begin
            nxt_col  = '0;
            nxt_row  = row + ONE;
            nxt_base = base + W_A + TWO;
        end
    end

    // Window sequencer; strt and rd_addr are registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            strt       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            rd_addr    <= '0;
            base       <= '0;
            row        <= '0;
            col        <= '0;
        end else begin
            strt       <= 1'b0;
            frame_done <= 1'b0;
            if (tx_done) begin
                state   <= IDLE;
                busy    <= 1'b0;
                rd_addr <= '0;
                base    <= '0;
                row     <= '0;
                col     <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (go) begin
                            busy <= 1'b1;
                            base <= '0;
                            row  <= '0;
                            col  <= '0;
                            if (!hold) begin
                                state   <= S0;
                                strt    <= 1'b1;
                                rd_addr <= '0;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (!hold) begin
                            state   <= S0;
                            strt    <= 1'b1;
                            rd_addr <= base;
                        end
                    end
                    S0: begin
                        state   <= S1;
                        rd_addr <= base + ONE;
                    end
                    S1: begin
                        state   <= S2;
                        rd_addr <= base + W_A;
                    end
                    S2: begin
                        state   <= S3;
                        rd_addr <= base + W_A + ONE;
                    end
                    S3: begin
                        state <= S4;
                    end
                    S4: begin
                        if (last_win) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            base <= nxt_base;
                            row  <= nxt_row;
                            col  <= nxt_col;
                            if (!hold) begin
                                state   <= S0;
                                strt    <= 1'b1;
                                rd_addr <= nxt_base;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: directed window tables, corner sequences
// and a randomized run against a window-level behavioural model.
module tb_pool_window_feeder;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int MW = 4;
    localparam int MH = 4;
    localparam int NW = (MW / 2) * (MH / 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0;
    logic hold = 1'b0;
    logic tx_done = 1'b0;
    logic go_b = 1'b0;

    logic        [AW-1:0] rd_addr;
    logic signed [DW-1:0] rd_data;
    logic signed [DW-1:0] dout;
    logic                 strt, busy, frame_done;

    logic        [1:0]    rd_addr_b;
    logic signed [DW-1:0] rd_data_b;
    logic signed [DW-1:0] dout_b;
    logic                 strt_b, busy_b, fd_b;

    logic signed [DW-1:0] mem [16];
    logic signed [DW-1:0] mem_b [4];

    always #5 clk = ~clk;

    // Source buffers: synchronous-read RAMs with one-cycle latency.
    always @(posedge clk) rd_data <= mem[rd_addr];
    always @(posedge clk) rd_data_b <= mem_b[rd_addr_b];

    pool_window_feeder #(
        .DATA_WIDTH(DW), .MAP_W(MW), .MAP_H(MH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .tx_done(tx_done),
        .hold(hold), .rd_addr(rd_addr), .rd_data(rd_data),
        .strt(strt), .dout(dout), .busy(busy), .frame_done(frame_done)
    );

    pool_window_feeder #(
        .DATA_WIDTH(DW), .MAP_W(2), .MAP_H(2), .ADDR_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .tx_done(tx_done),
        .hold(hold), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .strt(strt_b), .dout(dout_b), .busy(busy_b), .frame_done(fd_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int strt_log[$];
    int fd_log[$];
    int strt_b_log[$];
    int fd_b_log[$];
    longint dh[int];
    longint dbh[int];
    int ah[int];

    // Window-level model: which window, how far into it, and frame flags.
    int m_win;
    int m_pos;
    bit m_busy;
    bit m_wait;
    bit m_done;

    typedef struct {
        int     off;
        longint e[4];
    } win_t;

    win_t tbl[4];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int base_of(input int w);
        int r;
        int c;
        r = w / (MW / 2);
        c = w % (MW / 2);
        return r * 2 * MW + c * 2;
    endfunction

    function automatic int off_of(input int k);
        case (k)
            0: return 0;
            1: return 1;
            2: return MW;
            default: return MW + 1;
        endcase
    endfunction

    task automatic model_reset();
        m_win = 0;
        m_pos = -1;
        m_busy = 0;
        m_wait = 0;
        m_done = 0;
    endtask

    task automatic model_step(input bit g, input bit h, input bit t);
        if (t) begin
            model_reset();
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (g) begin
                m_busy = 1;
                m_win = 0;
                if (h) m_wait = 1;
                else m_pos = 0;
            end
        end else if (m_wait) begin
            if (!h) begin
                m_wait = 0;
                m_pos = 0;
            end
        end else if (m_pos >= 0 && m_pos < 4) begin
            m_pos++;
        end else if (m_pos == 4) begin
            m_pos = -1;
            if (m_win == NW - 1) begin
                m_done = 1;
            end else begin
                m_win++;
                if (h) m_wait = 1;
                else m_pos = 0;
            end
        end
    endtask

    task automatic step();
        bit g, h, t;
        g = go;
        h = hold;
        t = tx_done;
        @(posedge clk);
        cyc++;
        model_step(g, h, t);
        #1;
        chk("strt", strt, m_pos == 0);
        chk("busy", busy, m_busy);
        chk("frame_done", frame_done, m_done);
        if (m_pos >= 0 && m_pos <= 3)
            chk("rd_addr", rd_addr, base_of(m_win) + off_of(m_pos));
        if (m_pos >= 1)
            chk("dout", dout, mem[base_of(m_win) + off_of(m_pos - 1)]);
        if (strt) strt_log.push_back(cyc);
        if (frame_done) fd_log.push_back(cyc);
        if (strt_b) strt_b_log.push_back(cyc);
        if (fd_b) fd_b_log.push_back(cyc);
        dh[cyc] = dout;
        dbh[cyc] = dout_b;
        ah[cyc] = int'(rd_addr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        strt_log.delete();
        fd_log.delete();
        strt_b_log.delete();
        fd_b_log.delete();
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    initial begin
        int g0, g1, c1, s;
        longint eb[4];

        for (int i = 0; i < 16; i++) mem[i] = DW'(i);
        mem_b[0] = -18'sd3;
        mem_b[1] = 18'sd7;
        mem_b[2] = 18'sd2;
        mem_b[3] = -18'sd1;

        tbl[0].off = 0;  tbl[0].e = '{0, 1, 4, 5};
        tbl[1].off = 5;  tbl[1].e = '{2, 3, 6, 7};
        tbl[2].off = 10; tbl[2].e = '{8, 9, 12, 13};
        tbl[3].off = 15; tbl[3].e = '{10, 11, 14, 15};
        eb = '{-3, 7, 2, -1};

        model_reset();
        #12;
        chk("rst_strt", strt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        run(2);

        // Full 4x4 frame, no hold.
        clear_logs();
        pulse_go();
        g0 = cyc;
        run(23);
        chk("t1_nstrt", strt_log.size(), 4);
        for (int w = 0; w < 4; w++) begin
            chk("t1_strt", qget(strt_log, w), g0 + tbl[w].off);
            for (int k = 0; k < 4; k++)
                chk("t1_elem", dh[g0 + tbl[w].off + 1 + k], tbl[w].e[k]);
        end
        chk("t1_fd", qget(fd_log, 0), g0 + 20);
        chk("t1_nfd", fd_log.size(), 1);
        chk("t1_idle", busy, 0);

        // Minimum 2x2 map.
        clear_logs();
        go_b = 1'b1;
        step();
        go_b = 1'b0;
        g0 = cyc;
        run(7);
        chk("t2_nstrt", strt_b_log.size(), 1);
        chk("t2_strt", qget(strt_b_log, 0), g0);
        for (int k = 0; k < 4; k++)
            chk("t2_elem", dbh[g0 + 1 + k], eb[k]);
        chk("t2_fd", qget(fd_b_log, 0), g0 + 5);
        chk("t2_nfd", fd_b_log.size(), 1);
        chk("t2_idle", busy_b, 0);

        // Hold raised in S2 of window 1 for six cycles.
        clear_logs();
        pulse_go();
        g0 = cyc;
        run(7);
        hold = 1'b1;
        run(6);
        hold = 1'b0;
        run(16);
        chk("t3_s1", qget(strt_log, 1), g0 + 5);
        chk("t3_s2", qget(strt_log, 2), g0 + 14);
        chk("t3_s3", qget(strt_log, 3), g0 + 19);
        for (int k = 0; k < 4; k++)
            chk("t3_w1", dh[g0 + 6 + k], tbl[1].e[k]);
        chk("t3_fd", qget(fd_log, 0), g0 + 24);

        // Abort in S2 of window 2, then restart.
        clear_logs();
        pulse_go();
        g0 = cyc;
        run(12);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_strt", strt, 0);
        chk("t4_addr", rd_addr, 0);
        run(8);
        chk("t4_nofd", fd_log.size(), 0);
        clear_logs();
        pulse_go();
        g1 = cyc;
        run(23);
        chk("t4_rstrt", qget(strt_log, 0), g1);
        chk("t4_raddr", ah[g1], 0);
        for (int k = 0; k < 4; k++)
            chk("t4_relem", dh[g1 + 1 + k], tbl[0].e[k]);
        chk("t4_nfd", fd_log.size(), 1);

        // go pulsed mid-frame is ignored.
        clear_logs();
        pulse_go();
        g0 = cyc;
        run(7);
        pulse_go();
        run(16);
        chk("t5_nstrt", strt_log.size(), 4);
        for (int w = 0; w < 4; w++)
            chk("t5_strt", qget(strt_log, w), g0 + 5 * w);
        chk("t5_fd", qget(fd_log, 0), g0 + 20);

        // Back-to-back go with hold high.
        clear_logs();
        hold = 1'b1;
        go = 1'b1;
        step();
        c1 = cyc;
        step();
        go = 1'b0;
        run(3);
        chk("t6_nostrt", strt_log.size(), 0);
        hold = 1'b0;
        run(22);
        chk("t6_strt", qget(strt_log, 0), c1 + 5);
        chk("t6_nfd", fd_log.size(), 1);

        // Asynchronous reset while in S1.
        clear_logs();
        pulse_go();
        s = cyc;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_strt", strt, 0);
        chk("t7_busy", busy, 0);
        chk("t7_fd", frame_done, 0);
        chk("t7_addr", rd_addr, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        run(10);
        chk("t7_nostrt", strt_log.size(), 0);
        chk("t7_idle", busy, s > 0 ? 0 : 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 1500; i++) begin
            go = ($urandom_range(0, 15) == 0);
            hold = ($urandom_range(0, 3) == 0);
            tx_done = ($urandom_range(0, 149) == 0);
            step();
        end
        go = 1'b0;
        hold = 1'b0;
        tx_done = 1'b0;
        run(30);
        chk("end_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
